// File: rtl/rep_umul_seq.sv
// rep_umul_seq: sequencer for a single rep_uMUL unary multiplier.
//
// Takes a binary operand pair (A, B) over a valid/ready handshake. It loads B
// into the multiplier and clears the multiplier's Sobol generator. It then
// streams A as a thermometer code: the first A RUN cycles are 1 and the rest
// are 0. Each RUN cycle adds the multiplier's output bit to a count, and the
// final count is returned over a second valid/ready handshake.
//
// Ports
//   iClk, iRstN         clock, asynchronous active-low reset
//   iValid/oReady, iA/iB request handshake and operands
//   oValid/iReady/oProd result handshake and product count (0..2^BITWIDTH)
//   oBusy               high in LOAD/RUN/DONE
//   oMulA/oMulB         multiplier data inputs
//   oMulLoadB/oMulClr   multiplier B-capture and Sobol clear
//   iMulMult            multiplier output, combinational from oMulA
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request; operands latched on acceptance
// LOAD  | one cycle: multiplier captures B and clears its Sobol state
// RUN   | stream A as thermometer bits, count multiplier ones
// DONE  | result held on oProd/oValid until the consumer takes it
module rep_umul_seq #(
   parameter int BITWIDTH   = 8,
   parameter bit EARLY_TERM = 1'b0
) (
   input  logic                iClk,
   input  logic                iRstN,
   input  logic                iValid,
   output logic                oReady,
   input  logic [BITWIDTH-1:0] iA,
   input  logic [BITWIDTH-1:0] iB,
   output logic                oValid,
   input  logic                iReady,
   output logic [BITWIDTH:0]   oProd,
   output logic                oBusy,
   output logic                oMulA,
   output logic [BITWIDTH-1:0] oMulB,
   output logic                oMulLoadB,
   output logic                oMulClr,
   input  logic                iMulMult
);

   localparam int CW = BITWIDTH + 1;
   localparam logic [CW-1:0] LAST_FULL = {1'b0, {BITWIDTH{1'b1}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              r_state;
   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       r_acc;
   logic [BITWIDTH-1:0] r_a;
   logic [BITWIDTH-1:0] r_b;
   logic [CW-1:0]       r_prod;
   logic                r_valid;
   logic                r_loadb;
   logic                r_clr;
   logic [BITWIDTH-1:0] r_mulb;

   logic                w_mul_a;
   logic [CW-1:0]       w_a_ext;
   logic [CW-1:0]       w_acc_next;
   logic                w_last_early;
   logic                w_last;

   assign w_a_ext  = {1'b0, r_a};
   assign w_mul_a  = (r_state == RUN) && (r_cnt < w_a_ext);
   // Only bits streamed while oMulA is high can count.
   assign w_acc_next = r_acc + {{BITWIDTH{1'b0}}, (iMulMult & w_mul_a)};

   // When A is zero, A-1 wraps to all ones and never matches, so that case
   // is covered explicitly. It ends RUN after a single cycle.
   assign w_last_early = (r_a == '0) || (r_cnt == (w_a_ext - CW'(1)));
   assign w_last       = EARLY_TERM ? w_last_early : (r_cnt == LAST_FULL);

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_prod  <= '0;
         r_valid <= 1'b0;
         r_loadb <= 1'b0;
         r_clr   <= 1'b0;
         r_mulb  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (iValid) begin
                  r_a     <= iA;
                  r_b     <= iB;
                  r_mulb  <= iB;
                  r_loadb <= 1'b1;
                  r_clr   <= 1'b1;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               r_loadb <= 1'b0;
               r_clr   <= 1'b0;
               r_mulb  <= r_b;
               r_state <= RUN;
            end
            RUN: begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_prod  <= w_acc_next;
                  r_valid <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (iReady) begin
                  r_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign oReady    = (r_state == IDLE);
   assign oBusy     = (r_state != IDLE);
   assign oMulA     = w_mul_a;
   assign oMulB     = r_mulb;
   assign oMulLoadB = r_loadb;
   assign oMulClr   = r_clr;
   assign oValid    = r_valid;
   assign oProd     = r_prod;

endmodule

// File: tb/tb_rep_umul_seq.sv
// Bench for rep_umul_seq. It uses two lanes: lane 0 has EARLY_TERM=0 and
// lane 1 has EARLY_TERM=1. Each lane drives a behavioural rep_uMUL model
// built from a first-dimension Sobol (bit-reversed index) generator.
module tb_rep_umul_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [1:0]      valid, rdy_in, o_ready, o_valid, o_busy, mula, loadb, clr, mult;
   logic [1:0][7:0] a_in, b_in, mulb;
   logic [1:0][8:0] prod;

   int checks = 0;
   int fails  = 0;

   function automatic logic [7:0] bitrev(input logic [7:0] x);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = x[7-i];
      return r;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_lane
      logic [7:0] m_idx;
      logic [7:0] m_b;

      rep_umul_seq #(.BITWIDTH(8), .EARLY_TERM(g == 1)) dut (
         .iClk(clk), .iRstN(rst_n),
         .iValid(valid[g]), .oReady(o_ready[g]),
         .iA(a_in[g]), .iB(b_in[g]),
         .oValid(o_valid[g]), .iReady(rdy_in[g]), .oProd(prod[g]),
         .oBusy(o_busy[g]), .oMulA(mula[g]), .oMulB(mulb[g]),
         .oMulLoadB(loadb[g]), .oMulClr(clr[g]), .iMulMult(mult[g])
      );

      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            m_idx <= '0;
            m_b   <= '0;
         end else begin
            if (loadb[g]) m_b <= mulb[g];
            if (clr[g]) m_idx <= '0;
            else if (mula[g]) m_idx <= m_idx + 8'd1;
         end
      end

      assign mult[g] = mula[g] & (m_b > bitrev(m_idx));
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic accept(input int s, input int a, input int b);
      chk("ready_before_accept", int'(o_ready[s]), 1);
      valid[s] = 1'b1;
      a_in[s]  = 8'(a);
      b_in[s]  = 8'(b);
      @(posedge clk); #1;
      valid[s] = 1'b0;
      a_in[s]  = ~8'(a);
      b_in[s]  = ~8'(b);
      chk("busy_after_accept", int'(o_busy[s]), 1);
   endtask

   // The returned latency counts the accept cycle as cycle 0 and stops at
   // the first cycle in which oValid is high.
   task automatic wait_done(input int s, output int lat, output int ones,
                            output int nlb, output int nclr);
      lat = 1; ones = 0; nlb = 0; nclr = 0;
      while (!o_valid[s] && lat < 600) begin
         ones += int'(mula[s]);
         nlb  += int'(loadb[s]);
         nclr += int'(clr[s]);
         @(posedge clk); #1;
         lat++;
      end
      if (!o_valid[s]) chk("done_timeout", 0, 1);
   endtask

   task automatic release_res(input int s, input int exp_prod);
      rdy_in[s] = 1'b1;
      @(posedge clk); #1;
      rdy_in[s] = 1'b0;
      chk("valid_after_release", int'(o_valid[s]), 0);
      chk("ready_after_release", int'(o_ready[s]), 1);
      chk("prod_retained", int'(prod[s]), exp_prod);
   endtask

   typedef struct {
      int sel;
      int a;
      int b;
      int prod;
      int lat;
      int ones;
   } vec_t;

   vec_t tv[11];

   initial begin
      int lat, ones, nlb, nclr;

      tv[0]  = '{0, 128, 128,  64, 258, 128};
      tv[1]  = '{0,  64, 192,  48, 258,  64};
      tv[2]  = '{0,   0, 200,   0, 258,   0};
      tv[3]  = '{0, 200,   0,   0, 258, 200};
      tv[4]  = '{0, 255, 255, 255, 258, 255};
      tv[5]  = '{0,   1,   1,   1, 258,   1};
      tv[6]  = '{1,  64, 192,  48,  66,  64};
      tv[7]  = '{1,   0, 100,   0,   3,   0};
      tv[8]  = '{1, 128, 128,  64, 130, 128};
      tv[9]  = '{1,   1,   1,   1,   3,   1};
      tv[10] = '{1, 255, 255, 255, 257, 255};

      rst_n = 1'b1;
      valid = '0; rdy_in = '0; a_in = '0; b_in = '0;
      #1 rst_n = 1'b0;
      #1;
      for (int s = 0; s < 2; s++) begin
         chk("rst_ready", int'(o_ready[s]), 1);
         chk("rst_valid", int'(o_valid[s]), 0);
         chk("rst_prod",  int'(prod[s]), 0);
         chk("rst_busy",  int'(o_busy[s]), 0);
         chk("rst_mula",  int'(mula[s]), 0);
         chk("rst_loadb", int'(loadb[s]), 0);
         chk("rst_clr",   int'(clr[s]), 0);
         chk("rst_mulb",  int'(mulb[s]), 0);
      end
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) begin
         accept(tv[i].sel, tv[i].a, tv[i].b);
         wait_done(tv[i].sel, lat, ones, nlb, nclr);
         chk($sformatf("prod[%0d]", i), int'(prod[tv[i].sel]), tv[i].prod);
         chk($sformatf("lat[%0d]", i), lat, tv[i].lat);
         chk($sformatf("ones[%0d]", i), ones, tv[i].ones);
         chk($sformatf("loadb_cycles[%0d]", i), nlb, 1);
         chk($sformatf("clr_cycles[%0d]", i), nclr, 1);
         release_res(tv[i].sel, tv[i].prod);
      end

      // Back-pressure: the result must hold while iReady is low, and a
      // request raised during DONE is taken only after the return to IDLE.
      accept(0, 64, 192);
      wait_done(0, lat, ones, nlb, nclr);
      chk("bp_prod_first", int'(prod[0]), 48);
      valid[0] = 1'b1; a_in[0] = 8'd5; b_in[0] = 8'd7;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         chk("bp_valid_held", int'(o_valid[0]), 1);
         chk("bp_prod_held", int'(prod[0]), 48);
         chk("bp_ready_low", int'(o_ready[0]), 0);
      end
      rdy_in[0] = 1'b1;
      @(posedge clk); #1;
      rdy_in[0] = 1'b0;
      chk("bp_idle_ready", int'(o_ready[0]), 1);
      chk("bp_idle_valid", int'(o_valid[0]), 0);
      chk("bp_prod_kept", int'(prod[0]), 48);
      @(posedge clk); #1;
      valid[0] = 1'b0;
      chk("bp_new_accepted", int'(o_busy[0]), 1);
      wait_done(0, lat, ones, nlb, nclr);
      chk("bp_new_prod", int'(prod[0]), 1);
      chk("bp_new_lat", lat, 258);
      chk("bp_new_ones", ones, 5);
      release_res(0, 1);

      // Reset asserted in the middle of RUN.
      accept(0, 200, 100);
      @(posedge clk); #1;
      repeat (50) begin
         @(posedge clk); #1;
      end
      chk("mid_run_mula_high", int'(mula[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", int'(o_valid[0]), 0);
      chk("rst_mid_ready", int'(o_ready[0]), 1);
      chk("rst_mid_mula",  int'(mula[0]), 0);
      chk("rst_mid_busy",  int'(o_busy[0]), 0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      accept(0, 128, 128);
      wait_done(0, lat, ones, nlb, nclr);
      chk("post_rst_prod", int'(prod[0]), 64);
      chk("post_rst_lat", lat, 258);
      release_res(0, 64);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
